alu_sequencer: RTL and testbench

Instruction-cycle controller for the 4-bit ALU. It runs the free-running 8-phase cycle (A1 A2 A3 M1 M2 X1 X2 X3) and latches the opcode nibbles from the data bus. It decodes accumulator, register and immediate instructions into ALU select and op controls, and pulses the accumulator, carry and register write enables. It sits between the bus interface and the datapath: the ALU and the accumulator, carry and register-file registers are its only consumers.

---
 rtl/alu_sequencer_pkg.sv | 102 ++++++++++
 rtl/alu_sequencer_decode.sv | 130 +++++++++++++
 rtl/alu_sequencer.sv | 111 +++++++++++
 tb/tb_alu_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared encodings for the ALU instruction sequencer: phases, ALU control
// selects, opcode nibbles and the decoded control bundle.
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  typedef enum logic [2:0] {
    ALU_OP_PASS  = 3'd0,
    ALU_OP_ADD   = 3'd1,
    ALU_OP_ROL   = 3'd2,
    ALU_OP_ROR   = 3'd3,
    ALU_OP_DEC_A = 3'd4,
    ALU_OP_LG2_1 = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_IN0_ACC     = 3'd0,
    ALU_IN0_ACC_INV = 3'd1,
    ALU_IN0_REG     = 3'd2,
    ALU_IN0_REG_INV = 3'd3,
    ALU_IN0_DATA    = 3'd4
  } alu_in0_e;

  typedef enum logic [1:0] {
    ALU_IN1_ACC     = 2'd0,
    ALU_IN1_ONE     = 2'd1,
    ALU_IN1_ONE_INV = 2'd2
  } alu_in1_e;

  typedef enum logic [1:0] {
    ALU_CIN_CARRY     = 2'd0,
    ALU_CIN_CARRY_INV = 2'd1,
    ALU_CIN_ZERO      = 2'd2,
    ALU_CIN_ONE       = 2'd3
  } alu_cin_e;

  // OPR nibbles
  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_INC     = 4'h6;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_ADD     = 4'h8;
  localparam logic [3:0] OPR_SUB     = 4'h9;
  localparam logic [3:0] OPR_LD      = 4'hA;
  localparam logic [3:0] OPR_XCH     = 4'hB;
  localparam logic [3:0] OPR_LDM     = 4'hD;
  localparam logic [3:0] OPR_ACC_GRP = 4'hF;

  // OPA nibbles within the accumulator group
  localparam logic [3:0] OPA_CLB = 4'h0;
  localparam logic [3:0] OPA_CLC = 4'h1;
  localparam logic [3:0] OPA_IAC = 4'h2;
  localparam logic [3:0] OPA_CMC = 4'h3;
  localparam logic [3:0] OPA_CMA = 4'h4;
  localparam logic [3:0] OPA_RAL = 4'h5;
  localparam logic [3:0] OPA_RAR = 4'h6;
  localparam logic [3:0] OPA_TCC = 4'h7;
  localparam logic [3:0] OPA_DAC = 4'h8;
  localparam logic [3:0] OPA_TCS = 4'h9;
  localparam logic [3:0] OPA_STC = 4'hA;
  localparam logic [3:0] OPA_DAA = 4'hB;
  localparam logic [3:0] OPA_KBP = 4'hC;

  typedef struct packed {
    alu_op_e    op;
    alu_in0_e   in0;
    alu_in1_e   in1;
    alu_cin_e   cin;
    logic [3:0] data;
  } alu_ctrl_t;

  typedef struct packed {
    logic acc;
    logic carry;
    logic regf;
  } wr_mask_t;

  localparam alu_ctrl_t CTRL_IDLE = '{
    op:   ALU_OP_PASS,
    in0:  ALU_IN0_ACC,
    in1:  ALU_IN1_ACC,
    cin:  ALU_CIN_CARRY,
    data: 4'h0
  };

  function automatic logic is_two_word(logic [3:0] opr, logic [3:0] opa);
    return (opr == OPR_JCN) || (opr == OPR_JUN) || (opr == OPR_JMS) ||
           (opr == OPR_ISZ) || ((opr == OPR_FIM_SRC) && !opa[0]);
  endfunction

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode decoder: (OPR, OPA, carry) -> ALU controls, data
// operand, write-enable mask and the two-word flag.
module alu_decode
  import alu_sequencer_pkg::*;
(
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  input  logic       carry,
  output alu_ctrl_t  ctrl,
  output wr_mask_t   wr,
  output logic       two_word
);

  always_comb begin
    ctrl     = CTRL_IDLE;
    wr       = '0;
    two_word = is_two_word(opr, opa);

    case (opr)
      OPR_ADD: begin
        ctrl.op  = ALU_OP_ADD;
        ctrl.in0 = ALU_IN0_REG;
        wr.acc   = 1'b1;
        wr.carry = 1'b1;
      end
      OPR_SUB: begin
        ctrl.op  = ALU_OP_ADD;
        ctrl.in0 = ALU_IN0_REG_INV;
        ctrl.cin = ALU_CIN_CARRY_INV;
        wr.acc   = 1'b1;
        wr.carry = 1'b1;
      end
      OPR_LD: begin
        ctrl.in0 = ALU_IN0_REG;
        wr.acc   = 1'b1;
      end
      OPR_XCH: begin
        wr.regf = 1'b1;
      end
      OPR_INC, OPR_ISZ: begin
        ctrl.op  = ALU_OP_ADD;
        ctrl.in0 = ALU_IN0_REG;
        ctrl.in1 = ALU_IN1_ONE;
        ctrl.cin = ALU_CIN_ZERO;
        wr.regf  = 1'b1;
      end
      OPR_LDM: begin
        ctrl.in0  = ALU_IN0_DATA;
        ctrl.data = opa;
        wr.acc    = 1'b1;
      end
      OPR_ACC_GRP: begin
        case (opa)
          OPA_CLB: begin
            ctrl.in0 = ALU_IN0_DATA;
            ctrl.cin = ALU_CIN_ZERO;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_CLC: begin
            ctrl.cin = ALU_CIN_ZERO;
            wr.carry = 1'b1;
          end
          OPA_IAC: begin
            ctrl.op  = ALU_OP_ADD;
            ctrl.in1 = ALU_IN1_ONE;
            ctrl.cin = ALU_CIN_ZERO;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_CMC: begin
            ctrl.cin = ALU_CIN_CARRY_INV;
            wr.carry = 1'b1;
          end
          OPA_CMA: begin
            ctrl.in0 = ALU_IN0_ACC_INV;
            wr.acc   = 1'b1;
          end
          OPA_RAL: begin
            ctrl.op  = ALU_OP_ROL;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_RAR: begin
            ctrl.op  = ALU_OP_ROR;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_TCC: begin
            ctrl.in0  = ALU_IN0_DATA;
            ctrl.data = {3'b000, carry};
            ctrl.cin  = ALU_CIN_ZERO;
            wr.acc    = 1'b1;
            wr.carry  = 1'b1;
          end
          OPA_DAC: begin
            ctrl.op  = ALU_OP_ADD;
            ctrl.in1 = ALU_IN1_ONE_INV;
            ctrl.cin = ALU_CIN_ONE;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_TCS: begin
            ctrl.in0  = ALU_IN0_DATA;
            ctrl.data = carry ? 4'd10 : 4'd9;
            ctrl.cin  = ALU_CIN_ZERO;
            wr.acc    = 1'b1;
            wr.carry  = 1'b1;
          end
          OPA_STC: begin
            ctrl.cin = ALU_CIN_ONE;
            wr.carry = 1'b1;
          end
          OPA_DAA: begin
            ctrl.op  = ALU_OP_DEC_A;
            wr.acc   = 1'b1;
            wr.carry = 1'b1;
          end
          OPA_KBP: begin
            ctrl.op = ALU_OP_LG2_1;
            wr.acc  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Instruction-cycle controller: 8-phase counter, OPR/OPA latches, registered
// ALU controls for X1..X3 and X2-only commit strobes.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] bus_in,
  input  logic       carry,
  output logic [2:0] phase,
  output logic       sync,
  output logic [2:0] alu_op,
  output logic [2:0] alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic [1:0] alu_cin_sel,
  output logic [3:0] alu_data,
  output logic       acc_we,
  output logic       carry_we,
  output logic       reg_we,
  output logic [3:0] reg_idx
);

  phase_e     phase_q, phase_d;
  logic [3:0] opr_q, opr_d;
  logic [3:0] opa_q, opa_d;
  alu_ctrl_t  ctrl_q, ctrl_d;
  wr_mask_t   wr_q, wr_d;
  logic       two_word_q, two_word_d;
  logic       second_word_q, second_word_d;

  alu_ctrl_t  dec_ctrl;
  wr_mask_t   dec_wr;
  logic       dec_two_word;
  logic       strobe_win;

  // OPA is decoded straight from the bus so controls land on the M2 -> X1 edge
  alu_decode u_decode (
    .opr      (opr_q),
    .opa      (bus_in),
    .carry    (carry),
    .ctrl     (dec_ctrl),
    .wr       (dec_wr),
    .two_word (dec_two_word)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      phase_q       <= PH_A1;
      opr_q         <= '0;
      opa_q         <= '0;
      ctrl_q        <= CTRL_IDLE;
      wr_q          <= '0;
      two_word_q    <= 1'b0;
      second_word_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      opr_q         <= opr_d;
      opa_q         <= opa_d;
      ctrl_q        <= ctrl_d;
      wr_q          <= wr_d;
      two_word_q    <= two_word_d;
      second_word_q <= second_word_d;
    end
  end

  always_comb begin
    phase_d       = phase_e'(phase_q + 3'd1);
    opr_d         = opr_q;
    opa_d         = opa_q;
    ctrl_d        = ctrl_q;
    wr_d          = wr_q;
    two_word_d    = two_word_q;
    second_word_d = second_word_q;

    case (phase_q)
      PH_M1: opr_d = bus_in;
      PH_M2: begin
        opa_d = bus_in;
        if (!second_word_q) begin
          ctrl_d     = dec_ctrl;
          wr_d       = dec_wr;
          two_word_d = dec_two_word;
        end
      end
      PH_X3: begin
        ctrl_d        = CTRL_IDLE;
        wr_d          = '0;
        two_word_d    = 1'b0;
        // two_word_q is never set during a second word, so it cannot re-arm
        second_word_d = !second_word_q && two_word_q;
      end
      default: ;
    endcase
  end

  // Reset kills a strobe within the cycle it is raised, not one edge later
  assign strobe_win  = (phase_q == PH_X2) && !reset;

  assign phase       = phase_q;
  assign sync        = (phase_q == PH_X3);
  assign alu_op      = ctrl_q.op;
  assign alu_in0_sel = ctrl_q.in0;
  assign alu_in1_sel = ctrl_q.in1;
  assign alu_cin_sel = ctrl_q.cin;
  assign alu_data    = ctrl_q.data;
  assign acc_we      = wr_q.acc   && strobe_win;
  assign carry_we    = wr_q.carry && strobe_win;
  assign reg_we      = wr_q.regf  && strobe_win;
  assign reg_idx     = opa_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed instruction cycles followed
// by random ones, checked phase by phase against an instruction-level model.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] bus_in;
  logic       carry;
  logic [2:0] phase;
  logic       sync;
  logic [2:0] alu_op;
  logic [2:0] alu_in0_sel;
  logic [1:0] alu_in1_sel;
  logic [1:0] alu_cin_sel;
  logic [3:0] alu_data;
  logic       acc_we;
  logic       carry_we;
  logic       reg_we;
  logic [3:0] reg_idx;

  alu_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .bus_in      (bus_in),
    .carry       (carry),
    .phase       (phase),
    .sync        (sync),
    .alu_op      (alu_op),
    .alu_in0_sel (alu_in0_sel),
    .alu_in1_sel (alu_in1_sel),
    .alu_cin_sel (alu_cin_sel),
    .alu_data    (alu_data),
    .acc_we      (acc_we),
    .carry_we    (carry_we),
    .reg_we      (reg_we),
    .reg_idx     (reg_idx)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic [2:0] in0;
    logic [1:0] in1;
    logic [1:0] cin;
    logic [3:0] data;
    logic [2:0] we;    // {acc, carry, reg}
    logic       two;
  } exp_t;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         second = 1'b0;
  logic [3:0] prev_opa = 4'h0;

  function automatic exp_t mk(logic [2:0] op, logic [2:0] in0, logic [1:0] in1,
                              logic [1:0] cin, logic [3:0] d, logic [2:0] we);
    exp_t e;
    e.op = op; e.in0 = in0; e.in1 = in1; e.cin = cin; e.data = d; e.we = we;
    e.two = 1'b0;
    return e;
  endfunction

  function automatic exp_t idle();
    return mk(ALU_OP_PASS, ALU_IN0_ACC, ALU_IN1_ACC, ALU_CIN_CARRY, 4'h0, 3'b000);
  endfunction

  // Instruction table: what each opcode asks of the ALU and which registers it commits
  function automatic exp_t ref_model(logic [3:0] opr, logic [3:0] opa, logic c);
    exp_t e;
    e = idle();
    case (opr)
      4'h8: e = mk(ALU_OP_ADD,  ALU_IN0_REG,     ALU_IN1_ACC, ALU_CIN_CARRY,     0,   3'b110);
      4'h9: e = mk(ALU_OP_ADD,  ALU_IN0_REG_INV, ALU_IN1_ACC, ALU_CIN_CARRY_INV, 0,   3'b110);
      4'hA: e = mk(ALU_OP_PASS, ALU_IN0_REG,     ALU_IN1_ACC, ALU_CIN_CARRY,     0,   3'b100);
      4'hB: e = mk(ALU_OP_PASS, ALU_IN0_ACC,     ALU_IN1_ACC, ALU_CIN_CARRY,     0,   3'b001);
      4'h6,
      4'h7: e = mk(ALU_OP_ADD,  ALU_IN0_REG,     ALU_IN1_ONE, ALU_CIN_ZERO,      0,   3'b001);
      4'hD: e = mk(ALU_OP_PASS, ALU_IN0_DATA,    ALU_IN1_ACC, ALU_CIN_CARRY,     opa, 3'b100);
      4'hF: case (opa)
        4'h0: e = mk(ALU_OP_PASS,  ALU_IN0_DATA,    ALU_IN1_ACC,     ALU_CIN_ZERO,      0, 3'b110);
        4'h1: e = mk(ALU_OP_PASS,  ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_ZERO,      0, 3'b010);
        4'h2: e = mk(ALU_OP_ADD,   ALU_IN0_ACC,     ALU_IN1_ONE,     ALU_CIN_ZERO,      0, 3'b110);
        4'h3: e = mk(ALU_OP_PASS,  ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_CARRY_INV, 0, 3'b010);
        4'h4: e = mk(ALU_OP_PASS,  ALU_IN0_ACC_INV, ALU_IN1_ACC,     ALU_CIN_CARRY,     0, 3'b100);
        4'h5: e = mk(ALU_OP_ROL,   ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_CARRY,     0, 3'b110);
        4'h6: e = mk(ALU_OP_ROR,   ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_CARRY,     0, 3'b110);
        4'h7: e = mk(ALU_OP_PASS,  ALU_IN0_DATA,    ALU_IN1_ACC,     ALU_CIN_ZERO,      c ? 4'd1 : 4'd0, 3'b110);
        4'h8: e = mk(ALU_OP_ADD,   ALU_IN0_ACC,     ALU_IN1_ONE_INV, ALU_CIN_ONE,       0, 3'b110);
        4'h9: e = mk(ALU_OP_PASS,  ALU_IN0_DATA,    ALU_IN1_ACC,     ALU_CIN_ZERO,      c ? 4'd10 : 4'd9, 3'b110);
        4'hA: e = mk(ALU_OP_PASS,  ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_ONE,       0, 3'b010);
        4'hB: e = mk(ALU_OP_DEC_A, ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_CARRY,     0, 3'b110);
        4'hC: e = mk(ALU_OP_LG2_1, ALU_IN0_ACC,     ALU_IN1_ACC,     ALU_CIN_CARRY,     0, 3'b100);
        default: e = idle();
      endcase
      default: e = idle();
    endcase
    e.two = (opr == 4'h1) || (opr == 4'h4) || (opr == 4'h5) || (opr == 4'h7) ||
            ((opr == 4'h2) && (opa[0] == 1'b0));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full 8-phase instruction cycle, entered just after the edge into A1.
  // abort_ph < 8 asserts reset in that phase and ends the cycle there.
  task automatic do_cycle(input logic [3:0] opr, input logic [3:0] opa,
                          input logic c, input int abort_ph);
    exp_t e, cur;
    bit   sup;
    sup = second;
    e   = sup ? idle() : ref_model(opr, opa, c);
    for (int ph = 0; ph < 8; ph++) begin
      carry  = c;
      bus_in = (ph == 3) ? opr : (ph == 4) ? opa : 4'($urandom);
      if (ph == abort_ph) begin
        reset = 1'b1;
        #1;
        chk("abort_acc_we",   {7'b0, acc_we},   8'd0);
        chk("abort_carry_we", {7'b0, carry_we}, 8'd0);
        chk("abort_reg_we",   {7'b0, reg_we},   8'd0);
        @(posedge clock); #1;
        reset    = 1'b0;
        second   = 1'b0;
        prev_opa = 4'h0;
        chk("abort_phase",   {5'b0, phase},   8'd0);
        chk("abort_reg_idx", {4'b0, reg_idx}, 8'd0);
        return;
      end
      cur = (ph >= 5) ? e : idle();
      chk("phase",    {5'b0, phase},       8'(ph));
      chk("sync",     {7'b0, sync},        {7'b0, ph == 7});
      chk("alu_op",   {5'b0, alu_op},      {5'b0, cur.op});
      chk("in0_sel",  {5'b0, alu_in0_sel}, {5'b0, cur.in0});
      chk("in1_sel",  {6'b0, alu_in1_sel}, {6'b0, cur.in1});
      chk("cin_sel",  {6'b0, alu_cin_sel}, {6'b0, cur.cin});
      chk("alu_data", {4'b0, alu_data},    {4'b0, cur.data});
      chk("reg_idx",  {4'b0, reg_idx},     {4'b0, (ph >= 5) ? opa : prev_opa});
      chk("acc_we",   {7'b0, acc_we},      {7'b0, (ph == 6) && cur.we[2]});
      chk("carry_we", {7'b0, carry_we},    {7'b0, (ph == 6) && cur.we[1]});
      chk("reg_we",   {7'b0, reg_we},      {7'b0, (ph == 6) && cur.we[0]});
      @(posedge clock); #1;
    end
    prev_opa = opa;
    second   = sup ? 1'b0 : e.two;
  endtask

  initial begin
    reset  = 1'b1;
    bus_in = 4'h0;
    carry  = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_phase",    {5'b0, phase},       8'd0);
    chk("rst_sync",     {7'b0, sync},        8'd0);
    chk("rst_acc_we",   {7'b0, acc_we},      8'd0);
    chk("rst_carry_we", {7'b0, carry_we},    8'd0);
    chk("rst_reg_we",   {7'b0, reg_we},      8'd0);
    chk("rst_op",       {5'b0, alu_op},      {5'b0, ALU_OP_PASS});
    chk("rst_in0",      {5'b0, alu_in0_sel}, {5'b0, ALU_IN0_ACC});
    chk("rst_in1",      {6'b0, alu_in1_sel}, {6'b0, ALU_IN1_ACC});
    chk("rst_cin",      {6'b0, alu_cin_sel}, {6'b0, ALU_CIN_CARRY});
    chk("rst_data",     {4'b0, alu_data},    8'd0);
    chk("rst_reg_idx",  {4'b0, reg_idx},     8'd0);
    reset = 1'b0;

    do_cycle(4'h8, 4'h3, 1'b0, 8);   // ADD r3
    do_cycle(4'h8, 4'h5, 1'b1, 6);   // ADD aborted by reset in X2
    do_cycle(4'hF, 4'h9, 1'b1, 8);   // TCS carry=1 -> 10
    do_cycle(4'hF, 4'h9, 1'b0, 8);   // TCS carry=0 -> 9
    do_cycle(4'h4, 4'h0, 1'b0, 8);   // JUN first word
    do_cycle(4'hF, 4'h2, 1'b0, 8);   // second word: IAC suppressed
    do_cycle(4'hF, 4'h2, 1'b1, 8);   // IAC executes
    do_cycle(4'hF, 4'hC, 1'b0, 8);   // KBP
    do_cycle(4'h1, 4'h0, 1'b0, 8);   // JCN first word
    do_cycle(4'h4, 4'h0, 1'b0, 8);   // two-word opcode as second word: no re-arm
    do_cycle(4'h9, 4'h1, 1'b1, 8);   // SUB executes
    do_cycle(4'h2, 4'h1, 1'b0, 8);   // SRC (one word)
    do_cycle(4'hB, 4'h7, 1'b0, 8);   // XCH

    for (int i = 0; i < 48; i++) begin
      logic [3:0] r_opr, r_opa;
      int         ab;
      r_opr = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      r_opa = 4'($urandom);
      ab    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 8;
      do_cycle(r_opr, r_opa, 1'($urandom), ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
